// File: rtl/pbl_pkg.sv
// Shared types and default timing constants for the two-terminal request arbiter.
package pbl_pkg;

    // 1 ms debounce and 1 s post-acceptance hold at 50 MHz
    localparam int DEB_CYCLES_DEF  = 50000;
    localparam int HOLD_CYCLES_DEF = 50000000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_HOLD  = 2'd2
    } arb_state_t;

    typedef logic term_id_t;

    // What a terminal captures when its confirm button is pressed
    typedef struct packed {
        logic [3:0] hh;
        logic [1:0] b;
    } pend_t;

endpackage

// File: rtl/debounce_botao.sv
// Debouncer for one active-low, already synchronized pushbutton.
// Emits a one-cycle pulse when the debounced level falls (press); release is silent.
module debounce_botao
    import pbl_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n_i,
    output logic press_o
);

    localparam int                CNT_W    = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             db_q, db_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;

    // Count consecutive cycles the input disagrees with the accepted level;
    // any agreement restarts the count, the count never passes its last value.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (btn_n_i != db_q) begin
            if (cnt_q >= CNT_LAST) begin
                db_d = btn_n_i;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        press_d = db_q & ~db_d;
    end

    // Debounce state; released level is 1 so reset release never looks like a press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_q    <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/arbitro_terminais.sv
// Two-terminal request arbiter: synchronizes raw switches, debounces the confirm
// buttons, captures one pending request per terminal and grants them round-robin,
// with a fixed hold-off after every accepted grant.
module arbitro_terminais
    import pbl_pkg::*;
#(
    parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [3:0] HH0,
    input  logic [3:0] HH1,
    input  logic [1:0] B0,
    input  logic [1:0] B1,
    input  logic       CONF0,
    input  logic       CONF1,
    input  logic       REQ_READY,
    output logic       REQ_VALID,
    output logic       REQ_TERM,
    output logic [3:0] REQ_HH,
    output logic [1:0] REQ_B,
    output logic       PEND0,
    output logic       PEND1
);

    localparam int                 SYNC_W    = 14;
    // {CONF1, CONF0, B1, B0, HH1, HH0}; confirm paths idle high
    localparam logic [SYNC_W-1:0]  SYNC_RST  = 14'b11_00_00_0000_0000;
    localparam int                 HOLD_W    = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    logic [SYNC_W-1:0] sync1_q, sync2_q;
    logic [1:0][3:0]   hh_s;
    logic [1:0][1:0]   b_s;
    logic [1:0]        conf_s;
    logic [1:0]        press;

    pend_t [1:0]       pdata_q, pdata_d;
    logic [1:0]        pend_q, pend_d;

    arb_state_t        state_q, state_d;
    term_id_t          ptr_q, ptr_d;
    term_id_t          sel;
    logic              accept;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    term_id_t          req_term_q, req_term_d;
    logic [3:0]        req_hh_q, req_hh_d;
    logic [1:0]        req_b_q, req_b_d;

    // Two-flop synchronizer for every raw input
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q <= SYNC_RST;
            sync2_q <= SYNC_RST;
        end else begin
            sync1_q <= {CONF1, CONF0, B1, B0, HH1, HH0};
            sync2_q <= sync1_q;
        end
    end

    assign hh_s   = sync2_q[7:0];
    assign b_s    = sync2_q[11:8];
    assign conf_s = sync2_q[13:12];

    for (genvar t = 0; t < 2; t++) begin : g_deb
        debounce_botao #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk     (CLK),
            .rst_n   (RST_N),
            .btn_n_i (conf_s[t]),
            .press_o (press[t])
        );
    end

    assign accept = (state_q == ST_GRANT) && REQ_READY;

    // Pending registers: clear on acceptance of that terminal, otherwise capture
    // on a press only when empty (a press in the acceptance cycle sees PEND=1).
    always_comb begin
        pend_d  = pend_q;
        pdata_d = pdata_q;
        for (int t = 0; t < 2; t++) begin
            if (accept && (req_term_q == term_id_t'(t))) begin
                pend_d[t] = 1'b0;
            end else if (press[t] && !pend_q[t]) begin
                pend_d[t]     = 1'b1;
                pdata_d[t].hh = hh_s[t];
                pdata_d[t].b  = b_s[t];
            end
        end
    end

    // Arbiter next state: grant from IDLE, wait for handshake, then timed hold
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        req_term_d = req_term_q;
        req_hh_d   = req_hh_q;
        req_b_d    = req_b_q;
        sel        = (pend_q[0] && pend_q[1]) ? ptr_q : pend_q[1];
        case (state_q)
            ST_IDLE: begin
                if (|pend_q) begin
                    req_term_d = sel;
                    req_hh_d   = pdata_q[sel].hh;
                    req_b_d    = pdata_q[sel].b;
                    state_d    = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (REQ_READY) begin
                    ptr_d      = ~req_term_q;
                    hold_cnt_d = '0;
                    state_d    = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_q >= HOLD_LAST) begin
                    hold_cnt_d = '0;
                    state_d    = ST_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Arbiter and pending state registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            ptr_q      <= 1'b0;
            hold_cnt_q <= '0;
            req_term_q <= 1'b0;
            req_hh_q   <= '0;
            req_b_q    <= '0;
            pend_q     <= '0;
            pdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            req_term_q <= req_term_d;
            req_hh_q   <= req_hh_d;
            req_b_q    <= req_b_d;
            pend_q     <= pend_d;
            pdata_q    <= pdata_d;
        end
    end

    assign REQ_VALID = (state_q == ST_GRANT);
    assign REQ_TERM  = req_term_q;
    assign REQ_HH    = req_hh_q;
    assign REQ_B     = req_b_q;
    assign PEND0     = pend_q[0];
    assign PEND1     = pend_q[1];

endmodule

// File: tb/tb_arbitro_terminais.sv
// Directed bench for arbitro_terminais with short debounce/hold settings.
module tb_arbitro_terminais;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] hh0 = '0, hh1 = '0;
    logic [1:0] b0 = '0, b1 = '0;
    logic       conf0 = 1'b1, conf1 = 1'b1;
    logic       req_ready = 1'b0;
    logic       req_valid, req_term, pend0, pend1;
    logic [3:0] req_hh;
    logic [1:0] req_b;

    int checks = 0;
    int errors = 0;
    int n;

    always #5 clk = ~clk;

    arbitro_terminais #(.DEB_CYCLES(4), .HOLD_CYCLES(8)) dut (
        .CLK(clk), .RST_N(rst_n), .HH0(hh0), .HH1(hh1), .B0(b0), .B1(b1),
        .CONF0(conf0), .CONF1(conf1), .REQ_READY(req_ready),
        .REQ_VALID(req_valid), .REQ_TERM(req_term), .REQ_HH(req_hh), .REQ_B(req_b),
        .PEND0(pend0), .PEND1(pend1)
    );

    typedef struct {
        logic [1:0] mask;
        logic [3:0] hh0;
        logic [1:0] b0;
        logic [3:0] hh1;
        logic [1:0] b1;
        logic       t0;
        logic [3:0] ehh0;
        logic [1:0] eb0;
        logic       two;
        logic [3:0] ehh1;
        logic [1:0] eb1;
    } vec_t;

    vec_t vecs[4];
    vec_t v;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic step(input int cnt = 1);
        repeat (cnt) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; conf0 = 1'b1; conf1 = 1'b1; req_ready = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(2);
    endtask

    // Three 2-cycle low glitches, then held low
    task automatic press(input logic [1:0] m);
        for (int g = 0; g < 3; g++) begin
            if (m[0]) conf0 = 1'b0;
            if (m[1]) conf1 = 1'b0;
            step(2);
            conf0 = 1'b1; conf1 = 1'b1;
            step(2);
        end
        if (m[0]) conf0 = 1'b0;
        if (m[1]) conf1 = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int cnt);
        cnt = 0;
        while (!req_valid && cnt < budget) begin
            step(1);
            cnt++;
        end
        check("valid_timeout", {31'd0, req_valid}, 1);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_vld"},  {31'd0, req_valid}, 0);
        check({tag, "_term"}, {31'd0, req_term}, 0);
        check({tag, "_hh"},   {28'd0, req_hh}, 0);
        check({tag, "_b"},    {30'd0, req_b}, 0);
        check({tag, "_pend"}, {30'd0, pend1, pend0}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{2'b01, 4'b1011, 2'b10, 4'b0000, 2'b00, 1'b0, 4'b1011, 2'b10, 1'b0, 4'b0000, 2'b00};
        vecs[1] = '{2'b10, 4'b0000, 2'b00, 4'b0110, 2'b01, 1'b1, 4'b0110, 2'b01, 1'b0, 4'b0000, 2'b00};
        vecs[2] = '{2'b11, 4'b0011, 2'b11, 4'b1100, 2'b00, 1'b0, 4'b0011, 2'b11, 1'b1, 4'b1100, 2'b00};
        vecs[3] = '{2'b11, 4'b1111, 2'b01, 4'b0000, 2'b10, 1'b0, 4'b1111, 2'b01, 1'b1, 4'b0000, 2'b10};

        do_reset();
        check_zero_outputs("reset");

        // Table: press pattern -> expected grant(s)
        for (int i = 0; i < 4; i++) begin
            v = vecs[i];
            do_reset();
            hh0 = v.hh0; b0 = v.b0; hh1 = v.hh1; b1 = v.b1;
            step(1);
            press(v.mask);
            wait_valid(40, n);
            check($sformatf("v%0d_term", i), {31'd0, req_term}, {31'd0, v.t0});
            check($sformatf("v%0d_hh", i), {28'd0, req_hh}, {28'd0, v.ehh0});
            check($sformatf("v%0d_b", i), {30'd0, req_b}, {30'd0, v.eb0});
            req_ready = 1'b1; step(1); req_ready = 1'b0;
            check($sformatf("v%0d_vld_drop", i), {31'd0, req_valid}, 0);
            check($sformatf("v%0d_pend_clr", i), {31'd0, (v.t0 ? pend1 : pend0)}, 0);
            if (v.two) begin
                n = 0;
                while (!req_valid && n < 40) begin step(1); n++; end
                check($sformatf("v%0d_gap", i), n, 9);
                check($sformatf("v%0d_term2", i), {31'd0, req_term}, 1);
                check($sformatf("v%0d_hh2", i), {28'd0, req_hh}, {28'd0, v.ehh1});
                check($sformatf("v%0d_b2", i), {30'd0, req_b}, {30'd0, v.eb1});
                req_ready = 1'b1; step(1); req_ready = 1'b0;
                check($sformatf("v%0d_pend1_clr", i), {31'd0, pend1}, 0);
            end
            step(20);
            check($sformatf("v%0d_no_regrant", i), {31'd0, req_valid}, 0);
            conf0 = 1'b1; conf1 = 1'b1;
            step(12);
            check($sformatf("v%0d_release_quiet", i), {29'd0, req_valid, pend1, pend0}, 0);
        end

        // Backpressure: outputs frozen while switches move, accept on cycle 21
        do_reset();
        hh0 = 4'b0110; b0 = 2'b01;
        step(1);
        conf0 = 1'b0;
        wait_valid(40, n);
        for (int c = 0; c < 20; c++) begin
            hh0 = 4'(c); b0 = 2'(c);
            step(1);
            check("bp_vld", {31'd0, req_valid}, 1);
            check("bp_req", {25'd0, req_term, req_hh, req_b}, {25'd0, 1'b0, 4'b0110, 2'b01});
        end
        req_ready = 1'b1; step(1); req_ready = 1'b0;
        check("bp_accept", {30'd0, req_valid, pend0}, 0);
        step(3);
        check("hold_keeps", {25'd0, req_term, req_hh, req_b}, {25'd0, 1'b0, 4'b0110, 2'b01});
        conf0 = 1'b1; step(20);

        // Round-robin: both pending with pointer at terminal 1 after serving 0
        do_reset();
        hh0 = 4'b0101; b0 = 2'b01; hh1 = 4'b1010; b1 = 2'b10;
        conf0 = 1'b0;
        wait_valid(40, n);
        conf0 = 1'b1; step(10);
        conf1 = 1'b0; step(10);
        check("rr_pend1", {30'd0, pend1, req_valid}, 2'b11);
        req_ready = 1'b1; conf0 = 1'b0; step(1); req_ready = 1'b0;
        n = 0;
        while (!req_valid && n < 40) begin step(1); n++; end
        check("rr_gap", n, 9);
        check("rr_first", {25'd0, req_term, req_hh, req_b}, {25'd0, 1'b1, 4'b1010, 2'b10});
        req_ready = 1'b1; step(1); req_ready = 1'b0;
        wait_valid(40, n);
        check("rr_second", {25'd0, req_term, req_hh, req_b}, {25'd0, 1'b0, 4'b0101, 2'b01});
        req_ready = 1'b1; step(1); req_ready = 1'b0;
        conf0 = 1'b1; conf1 = 1'b1; step(20);

        // Second press while pending is ignored
        do_reset();
        hh0 = 4'b0010; b0 = 2'b00; hh1 = 4'b0111; b1 = 2'b01;
        conf0 = 1'b0;
        wait_valid(40, n);
        conf1 = 1'b0; step(10);
        check("dup_pend1", {31'd0, pend1}, 1);
        conf1 = 1'b1; step(10);
        hh1 = 4'b0001; b1 = 2'b11;
        conf1 = 1'b0; step(10);
        req_ready = 1'b1; step(1); req_ready = 1'b0;
        wait_valid(40, n);
        check("dup_kept", {25'd0, req_term, req_hh, req_b}, {25'd0, 1'b1, 4'b0111, 2'b01});
        conf0 = 1'b1; conf1 = 1'b1;

        // Reset mid-GRANT
        do_reset();
        hh1 = 4'b1111; b1 = 2'b11;
        conf1 = 1'b0;
        wait_valid(40, n);
        conf1 = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("rst_grant");
        step(2); rst_n = 1'b1; step(30);
        check("rst_grant_after", {30'd0, req_valid, pend1}, 0);

        // Reset mid-HOLD
        do_reset();
        hh1 = 4'b1101; b1 = 2'b10;
        conf1 = 1'b0;
        wait_valid(40, n);
        req_ready = 1'b1; step(1); req_ready = 1'b0;
        step(3);
        check("hold_state", {25'd0, req_valid, req_term, req_hh, req_b}, {25'd0, 1'b0, 1'b1, 4'b1101, 2'b10});
        conf1 = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("rst_hold");
        step(2); rst_n = 1'b1; step(30);
        check("rst_hold_after", {30'd0, req_valid, pend1}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arbitro_terminais.md
ARBITRO_TERMINAIS -- requirements
Module: arbitro_terminais

Interface
REQ-001 DEB_CYCLES, 50000, clock cycles a confirm button must be stable before its level is accepted (1 ms at 50 MHz).
REQ-002 HOLD_CYCLES, 50000000, clock cycles the granted request is held after acceptance before the next grant (1 s at 50 MHz).
REQ-003 CLK  input  1  single system clock; all state changes on its rising edge.
REQ-004 RST_N  input  1  asynchronous, active-low reset.
REQ-005 HH0, HH1  input  4 each  raw terminal 0/1 code switches, asynchronous to CLK.
REQ-006 B0, B1  input  2 each  raw terminal 0/1 function switches, asynchronous.
REQ-007 CONF0, CONF1  input  1 each  raw terminal 0/1 confirm pushbuttons, active-low, bouncing.
REQ-008 REQ_READY  input  1  downstream authentication/function stage accepts the request.
REQ-009 REQ_VALID  output  1  a granted request is presented.
REQ-010 REQ_TERM  output  1  terminal number of the presented request (0 or 1).
REQ-011 REQ_HH  output  4  captured code of the presented request.
REQ-012 REQ_B  output  2  captured function bits of the presented request.
REQ-013 PEND0, PEND1  output  1 each  terminal 0/1 has a captured, unserved request.

Function
REQ-014 All raw inputs SHALL pass a 2-flop synchronizer before any use; synchronizer latency 2 cycles.
REQ-015 Each synchronized CONFx SHALL feed a debouncer whose output changes only after the input has been stable, differing from the output, for DEB_CYCLES consecutive cycles; any change restarts the count.
REQ-016 A 1-to-0 transition of a debounced CONFx SHALL produce a single-cycle press pulse; release produces nothing.
REQ-017 On a press pulse with PENDx=0, the synchronized HHx/Bx SHALL be stored in terminal x's pending register and PENDx set next cycle.
REQ-018 A press pulse with PENDx=1 SHALL be ignored; stored values unchanged.
REQ-019 Simultaneous press pulses on both terminals SHALL capture both.
REQ-020 Arbiter FSM states: IDLE, GRANT, HOLD.
REQ-021 IDLE: if exactly one PENDx=1, select x; if both, select the terminal indicated by the round-robin pointer; move to GRANT next cycle with REQ_* loaded from the selected pending register.
REQ-022 GRANT: REQ_VALID=1; REQ_TERM/REQ_HH/REQ_B SHALL stay constant until REQ_VALID&REQ_READY.
REQ-023 On REQ_VALID&REQ_READY: clear PEND of the granted terminal, set pointer to the other terminal, go to HOLD; REQ_VALID=0 next cycle.
REQ-024 A press on the granted terminal in the acceptance cycle SHALL be ignored (PENDx still 1 that cycle).
REQ-025 HOLD: REQ_VALID=0; REQ_TERM/REQ_HH/REQ_B keep last granted values; after exactly HOLD_CYCLES cycles go to IDLE.
REQ-026 Captures SHALL continue during GRANT and HOLD for the non-busy terminal.
REQ-027 Counters SHALL be sized ceil(log2(N+1)) of their parameter and SHALL saturate, never wrap.

Reset
REQ-028 RST_N low SHALL immediately force: FSM=IDLE, REQ_VALID=0, REQ_TERM=0, REQ_HH=0, REQ_B=0, PEND0=PEND1=0, pointer=terminal 0, counters=0, debounced CONFx=1, synchronizer flops=0 except CONFx paths=1.
REQ-029 Reset asserted mid-GRANT or mid-HOLD SHALL discard the request; no press pulse SHALL be generated on reset release.

Structure
REQ-030 Shared package pbl_pkg SHALL hold the FSM state enum, terminal-id type, and default DEB_CYCLES/HOLD_CYCLES constants.
REQ-031 Debounce+edge logic SHALL be one sub-module, debounce_botao, instantiated twice.

Verification (DEB_CYCLES=4, HOLD_CYCLES=8)
REQ-032 Press CONF0 with HH0=4'b1011, B0=2'b10, bounce 3 glitches of 2 cycles -> single capture, PEND0=1, then REQ_VALID=1, REQ_TERM=0, REQ_HH=1011, REQ_B=10.
REQ-033 Both confirm pressed same cycle after reset, REQ_READY=1 -> grants terminal 0 then terminal 1, second grant exactly 8+1 cycles after first acceptance.
REQ-034 REQ_READY=0 for 20 cycles while HH0 switches change -> REQ_* stable, REQ_VALID held 1; accept on cycle 21 -> PEND0=0.
REQ-035 Second CONF1 press while PEND1=1 with new HH1=4'b0001 -> ignored; served request keeps the first value.
REQ-036 RST_N low during HOLD and during GRANT -> all outputs 0 asynchronously, no grant after release without a new press.
